// File: rtl/mand_solver_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mand_solver_pipe
// Brief    : Escape-time fractal solver with valid/ready request and result
//            handshakes and a pass-through pixel tag. The optional Julia
//            constant ports are enabled with the MAND_SOLVER_JULIA_EN macro.
// Revision : 1.0
// ============================================================================
module mand_solver_pipe #(
    parameter int INT_BITS   = 7,
    parameter int FRAC_BITS  = 20,
    parameter int ITER_BITS  = 16,
    parameter int TAG_BITS   = 20,
    parameter int ESCAPE_MAG = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]    in_c_re,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]    in_c_im,
    input  logic        [ITER_BITS-1:0]             in_max_iter,
    input  logic        [TAG_BITS-1:0]              in_tag,
`ifdef MAND_SOLVER_JULIA_EN
    input  logic                                    in_julia,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]    julia_re,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]    julia_im,
`endif
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic        [ITER_BITS:0]               out_iter,
    output logic        [TAG_BITS-1:0]              out_tag
);

    localparam int W = INT_BITS + FRAC_BITS;
    localparam logic signed [W:0] c_esc_limit = (W+1)'(ESCAPE_MAG) << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                   r_in_ready;
    logic signed [W-1:0]    r_z_re;
    logic signed [W-1:0]    r_z_im;
    logic signed [W-1:0]    r_k_re;
    logic signed [W-1:0]    r_k_im;
    logic [ITER_BITS-1:0]   r_max_iter;
    logic [ITER_BITS-1:0]   r_iter;
    logic [TAG_BITS-1:0]    r_tag;
    logic [ITER_BITS:0]     r_out_iter;
    logic [TAG_BITS-1:0]    r_out_tag;

    logic signed [W-1:0]    w_k_re;
    logic signed [W-1:0]    w_k_im;
    logic signed [2*W-1:0]  w_p_rr;
    logic signed [2*W-1:0]  w_p_ii;
    logic signed [2*W-1:0]  w_p_ri;
    logic signed [W-1:0]    w_re2;
    logic signed [W-1:0]    w_im2;
    logic signed [W-1:0]    w_2ri;
    logic signed [W:0]      w_mag;
    logic signed [W-1:0]    w_nz_re;
    logic signed [W-1:0]    w_nz_im;
    logic                   w_escape;
    logic                   w_at_limit;
    logic                   w_accept;

`ifdef MAND_SOLVER_JULIA_EN
    assign w_k_re = in_julia ? julia_re : in_c_re;
    assign w_k_im = in_julia ? julia_im : in_c_im;
`else
    assign w_k_re = in_c_re;
    assign w_k_im = in_c_im;
`endif

    // The three shared products feed both the escape test and the z update.
    assign w_p_rr = (2*W)'(r_z_re) * (2*W)'(r_z_re);
    assign w_p_ii = (2*W)'(r_z_im) * (2*W)'(r_z_im);
    assign w_p_ri = (2*W)'(r_z_re) * (2*W)'(r_z_im);

    assign w_re2 = W'(w_p_rr >>> FRAC_BITS);
    assign w_im2 = W'(w_p_ii >>> FRAC_BITS);
    // Doubling folded into the shift: floor(2*re*im / 2^FRAC_BITS).
    assign w_2ri = W'(w_p_ri >>> (FRAC_BITS - 1));

    assign w_mag   = (W+1)'(w_re2) + (W+1)'(w_im2);
    assign w_nz_re = w_re2 - w_im2 + r_k_re;
    assign w_nz_im = w_2ri + r_k_im;

    assign w_escape   = (w_mag > c_esc_limit);
    assign w_at_limit = (r_iter == r_max_iter);
    assign w_accept   = in_valid && r_in_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign out_iter  = r_out_iter;
    assign out_tag   = r_out_tag;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_escape || w_at_limit) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == IDLE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_z_re     <= '0;
            r_z_im     <= '0;
            r_k_re     <= '0;
            r_k_im     <= '0;
            r_max_iter <= '0;
            r_iter     <= '0;
            r_tag      <= '0;
            r_out_iter <= '0;
            r_out_tag  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_z_re     <= in_c_re;
                        r_z_im     <= in_c_im;
                        r_k_re     <= w_k_re;
                        r_k_im     <= w_k_im;
                        r_max_iter <= in_max_iter;
                        r_tag      <= in_tag;
                        r_iter     <= '0;
                    end
                end
                RUN: begin
                    if (w_escape) begin
                        r_out_iter <= {1'b0, r_iter};
                        r_out_tag  <= r_tag;
                    end else if (w_at_limit) begin
                        r_out_iter <= '1;
                        r_out_tag  <= r_tag;
                    end else begin
                        r_z_re <= w_nz_re;
                        r_z_im <= w_nz_im;
                        r_iter <= r_iter + ITER_BITS'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_iter <= '0;
                        r_out_tag  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mand_solver_pipe.sv
`default_nettype none
// Testbench for mand_solver_pipe: directed corner pixels plus randomized
// pixels checked against a plain-arithmetic escape-time model.
module tb_mand_solver_pipe;

    localparam int INT_BITS   = 7;
    localparam int FRAC_BITS  = 20;
    localparam int ITER_BITS  = 16;
    localparam int TAG_BITS   = 20;
    localparam int ESCAPE_MAG = 4;
    localparam int W          = INT_BITS + FRAC_BITS;
    localparam longint ONE    = 64'sd1 <<< FRAC_BITS;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_c_re;
    logic [W-1:0]          in_c_im;
    logic [ITER_BITS-1:0]  in_max_iter;
    logic [TAG_BITS-1:0]   in_tag;
    logic                  in_julia;
    logic [W-1:0]          julia_re;
    logic [W-1:0]          julia_im;
    logic                  out_valid;
    logic                  out_ready;
    logic [ITER_BITS:0]    out_iter;
    logic [TAG_BITS-1:0]   out_tag;

    int                    n_tests = 0;
    int                    n_fail  = 0;
    logic [ITER_BITS:0]    last_iter;
    int                    last_lat;

    mand_solver_pipe #(
        .INT_BITS   (INT_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .ITER_BITS  (ITER_BITS),
        .TAG_BITS   (TAG_BITS),
        .ESCAPE_MAG (ESCAPE_MAG)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_c_re     (in_c_re),
        .in_c_im     (in_c_im),
        .in_max_iter (in_max_iter),
        .in_tag      (in_tag),
`ifdef MAND_SOLVER_JULIA_EN
        .in_julia    (in_julia),
        .julia_re    (julia_re),
        .julia_im    (julia_im),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_iter    (out_iter),
        .out_tag     (out_tag)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reduce to a signed W-bit value (two's-complement wrap).
    function automatic longint wrapw(input longint x);
        longint s;
        s = x <<< (64 - W);
        return s >>> (64 - W);
    endfunction

    // Escape-time reference: result count (or -1) and number of z updates.
    function automatic void model(input longint cre, input longint cim,
                                  input longint kre, input longint kim,
                                  input int maxit, output int res, output int nupd);
        longint zr, zi, rr, ii, nzr;
        zr = cre;
        zi = cim;
        res = -1;
        nupd = 0;
        for (int n = 0; n <= maxit; n++) begin
            rr = wrapw((zr * zr) >>> FRAC_BITS);
            ii = wrapw((zi * zi) >>> FRAC_BITS);
            if (rr + ii > (longint'(ESCAPE_MAG) <<< FRAC_BITS)) begin
                res = n;
                nupd = n;
                return;
            end
            if (n == maxit) begin
                res = -1;
                nupd = n;
                return;
            end
            nzr = wrapw(rr - ii + kre);
            zi  = wrapw(((2 * zr * zi) >>> FRAC_BITS) + kim);
            zr  = nzr;
        end
    endfunction

    task automatic run_pixel(input string name, input longint cre, input longint cim,
                             input int maxit, input logic [TAG_BITS-1:0] tag,
                             input bit julia, input longint jre, input longint jim,
                             input int hold, input bit spam);
        int res, nupd, lat, budget;
        longint kre, kim;
        logic [ITER_BITS:0] exp_iter;
        kre = cre;
        kim = cim;
`ifdef MAND_SOLVER_JULIA_EN
        if (julia) begin
            kre = jre;
            kim = jim;
        end
`endif
        model(cre, cim, kre, kim, maxit, res, nupd);
        exp_iter = (res < 0) ? '1 : res[ITER_BITS:0];

        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(posedge clock); #1;
            budget++;
        end
        check_eq({name, "_ready"}, in_ready, 1);

        in_valid    = 1'b1;
        in_c_re     = cre[W-1:0];
        in_c_im     = cim[W-1:0];
        in_max_iter = maxit[ITER_BITS-1:0];
        in_tag      = tag;
        in_julia    = julia;
        julia_re    = jre[W-1:0];
        julia_im    = jim[W-1:0];
        out_ready   = (hold == 0);
        @(posedge clock); #1;
        in_valid = spam;
        if (spam) begin
            in_tag  = ~tag;
            in_c_re = '0;
            in_c_im = '0;
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < maxit + 10) begin
            check_eq({name, "_busy_ready"}, in_ready, 0);
            @(posedge clock); #1;
            lat++;
        end
        in_valid = 1'b0;
        check_eq({name, "_valid"}, out_valid, 1);
        check_eq({name, "_latency"}, lat, nupd + 2);
        check_eq({name, "_iter"}, out_iter, exp_iter);
        check_eq({name, "_tag"}, out_tag, tag);
        check_eq({name, "_done_ready"}, in_ready, 0);
        last_iter = out_iter;
        last_lat  = lat;

        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check_eq({name, "_hold_valid"}, out_valid, 1);
            check_eq({name, "_hold_iter"}, out_iter, exp_iter);
            check_eq({name, "_hold_tag"}, out_tag, tag);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_eq({name, "_clr_valid"}, out_valid, 0);
        check_eq({name, "_clr_iter"}, out_iter, 0);
        check_eq({name, "_clr_tag"}, out_tag, 0);
        check_eq({name, "_idle_ready"}, in_ready, 1);
        if (spam) begin
            @(posedge clock); #1;
            check_eq({name, "_no_rerun"}, in_ready, 1);
        end
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_c_re     = '0;
        in_c_im     = '0;
        in_max_iter = '0;
        in_tag      = '0;
        in_julia    = 1'b0;
        julia_re    = '0;
        julia_im    = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_iter", out_iter, 0);
        check_eq("rst_tag", out_tag, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("post_rst_ready", in_ready, 1);

        run_pixel("c1", ONE, 0, 100, 20'hABCDE, 0, 0, 0, 0, 0);
        check_eq("c1_const_iter", last_iter, 2);
        check_eq("c1_const_lat", last_lat, 4);

        run_pixel("c3", 3 * ONE, 0, 100, 20'h00033, 0, 0, 0, 0, 0);
        check_eq("c3_const_iter", last_iter, 0);

        run_pixel("c0", 0, 0, 100, 20'h00001, 0, 0, 0, 0, 0);
        check_eq("c0_const_iter", last_iter, 17'h1FFFF);
        check_eq("c0_const_lat", last_lat, 102);

        run_pixel("cm2", -2 * ONE, 0, 100, 20'h000F2, 0, 0, 0, 0, 0);
        check_eq("cm2_const_iter", last_iter, 17'h1FFFF);

        run_pixel("mx0", ONE / 2, ONE / 2, 0, 20'h55555, 0, 0, 0, 0, 1);
        check_eq("mx0_const_iter", last_iter, 17'h1FFFF);
        check_eq("mx0_const_lat", last_lat, 2);

        run_pixel("hold", ONE, 0, 100, 20'h12345, 0, 0, 0, 10, 0);

        // Abort a pixel on its third RUN cycle.
        in_valid    = 1'b1;
        in_c_re     = '0;
        in_c_im     = '0;
        in_max_iter = 16'd100;
        in_tag      = 20'h0BAD0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_ready", in_ready, 0);
        check_eq("abort_tag", out_tag, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("abort_ready_after", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 110; i++) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clock); #1;
        end
        check_eq("abort_no_result", seen, 0);
        run_pixel("after_abort", ONE, 0, 100, 20'h0AAAA, 0, 0, 0, 0, 0);
        check_eq("after_abort_iter", last_iter, 2);

`ifdef MAND_SOLVER_JULIA_EN
        run_pixel("julia", 0, 0, 100, 20'h0F00D, 1, ONE / 2, 0, 0, 0);
        check_eq("julia_const_iter", last_iter, 5);
`endif

        for (int t = 0; t < 40; t++) begin
            longint cre, cim, jre, jim;
            bit jul;
            cre = longint'($urandom_range(0, 4 << FRAC_BITS)) - 2 * ONE;
            cim = longint'($urandom_range(0, 4 << FRAC_BITS)) - 2 * ONE;
            jre = longint'($urandom_range(0, 2 << FRAC_BITS)) - ONE;
            jim = longint'($urandom_range(0, 2 << FRAC_BITS)) - ONE;
`ifdef MAND_SOLVER_JULIA_EN
            jul = 1'($urandom_range(0, 1));
`else
            jul = 1'b0;
`endif
            run_pixel("rnd", cre, cim, int'($urandom_range(0, 40)),
                      TAG_BITS'($urandom), jul, jre, jim,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
